multi_player_input_queue: RTL and testbench
===========================================

Name: multi_player_input_queue

Overview:
- Parametrised successor to the per-player arrow/shake decode in the top level. Turns the PS/2 byte stream and the shake-sensor inputs into queued arrow events for NUM_PLAYERS processors.
- Adds three things the current top level lacks: break-code and typematic suppression, shake-sensor synchronisation and debouncing, and a per-player FIFO with a valid/ready handshake.
- Sits between PS2_Interface and the processor instances.

Parameters:
- NUM_PLAYERS, 2: number of player channels, 1..4.
- FIFO_DEPTH, 4: entries per player FIFO; power of two, at least 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required on a shake input (5 ms at 10 MHz).
- KEYMAP, {8'h74,8'h72,8'h6b,8'h75,8'h23,8'h1b,8'h1c,8'h1d}: flattened width 32*NUM_PLAYERS. Player p occupies bits [32p+31:32p], ordered right, down, left, up, high byte to low byte.

Ports:
- clock  in  1  system clock (10 MHz PLL output)
- resetn  in  1  asynchronous active-low reset
- clear  in  1  synchronous game clear (same source as game_reset); flushes all state
- ps2_key_pressed  in  1  one-cycle strobe, new byte valid
- ps2_key_data  in  8  received scan-code byte
- shake_in  in  NUM_PLAYERS  raw asynchronous shake sensor levels
- out_valid  out  NUM_PLAYERS  FIFO p non-empty
- out_ready  in  NUM_PLAYERS  consumer p pops the head this cycle
- out_arrow  out  8*NUM_PLAYERS  FIFO p head, bits [8p+7:8p]; 8'h00 when empty
- overflow  out  NUM_PLAYERS  sticky flag: an event was dropped for player p

Behaviour:
- Reset (resetn low, asynchronous) and clear (synchronous, high) both zero the following:
  - FIFOs, out_valid, out_arrow, overflow
  - held bits, break_flag, shake_pending
  - synchronisers, debounce counters, debounced levels
- Arrow codes, bits [7:3]=0:
  - up 3'b001, left 3'b010, down 3'b011, right 3'b100, shake 3'b101.
- Byte parser, evaluated on each ps2_key_pressed strobe:
  - 8'hE0: ignored; break_flag unchanged.
  - 8'hF0: sets break_flag.
  - Other byte with break_flag=1: clears held[p][k] for every matching (p,k); no event; break_flag cleared.
  - Other byte with break_flag=0, matching key (p,k) with held clear: enqueue arrow k to player p and set held[p][k].
  - Same case with held already set: ignored (typematic repeat).
  - Unmatched bytes: no effect.
  - A byte present in several players' maps produces an event for each matching player.
- Shake path, per player:
  - 2-FF synchroniser.
  - Debounced level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any agreement.
  - A rising edge of the debounced level sets shake_pending.
  - A falling edge produces no event.
- FIFO write port, one per player:
  - A keyboard event has priority.
  - shake_pending is written (code 5) on the first cycle with no keyboard write to that player, then cleared.
  - A second rising edge while shake_pending is set merges into the pending event; it is not counted as an overflow.
- Latency:
  - Keyboard: strobe in cycle t, out_valid/out_arrow updated at the t+1 edge.
  - Shake: enqueue one cycle after the debounced edge when the port is free.
- Handshake: a pop happens on any edge with out_valid & out_ready. out_arrow shows the next entry, or 0, on the following cycle.
- Full FIFO:
  - An incoming write is dropped and overflow[p] is set; overflow stays set until reset or clear.
  - A write and a pop in the same cycle on a full FIFO both succeed; count is unchanged, no overflow.
- Empty FIFO: out_ready is ignored; no underflow.
- Occupancy counter: log2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
- clear asserted at the same time as ps2_key_pressed: clear wins and the byte is discarded.

Test Plan (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
1. Strobe 8'h1d, out_ready=0 -> next cycle out_valid[0]=1, out_arrow[7:0]=8'h01, out_valid[1]=0. Then strobe E0,75 -> out_arrow[15:8]=8'h01.
2. Strobe 1c,1c,1c (typematic), then F0,1c, then 1c -> exactly two entries of 8'h02 in FIFO 0.
3. Hold out_ready[0]=0; send 1d F0 1d 1c F0 1c 1b F0 1b 23 F0 23 1d -> four entries 01,02,03,04; overflow[0]=1 after the fifth make. Then a write and a pop in the same cycle -> count stays 4, head 02.
4. Drive shake_in[1] high with a 3-cycle glitch low after 2 cycles, then hold high -> exactly one 8'h05 event, no earlier than 2+4 cycles after the last transition. Releasing and re-asserting after 5 cycles -> second 8'h05.
5. Shake debounced edge in the same cycle as a player 1 keyboard strobe 8'h74 -> FIFO 1 order 04 then 05; no overflow.
6. Fill FIFO 0 with two entries and set break_flag via F0. Pulse clear for one cycle -> out_valid=0, overflow=0. Next byte 1d yields a make event (8'h01).

Source files
------------

// File: rtl/multi_player_input_queue_if.sv
// Player-input bundle: PS/2 byte strobe, raw shake levels and the per-player
// arrow-event valid/ready outputs shared by the queue and its consumers.
interface multi_player_input_queue_if #(
    parameter int NUM_PLAYERS = 2
);
    logic                       ps2_key_pressed;
    logic [7:0]                 ps2_key_data;
    logic [NUM_PLAYERS-1:0]     shake_in;
    logic [NUM_PLAYERS-1:0]     out_valid;
    logic [NUM_PLAYERS-1:0]     out_ready;
    logic [8*NUM_PLAYERS-1:0]   out_arrow;
    logic [NUM_PLAYERS-1:0]     overflow;

    modport master (
        input  ps2_key_pressed, ps2_key_data, shake_in, out_ready,
        output out_valid, out_arrow, overflow
    );

    modport slave (
        output ps2_key_pressed, ps2_key_data, shake_in, out_ready,
        input  out_valid, out_arrow, overflow
    );
endinterface

// File: rtl/multi_player_input_queue.sv
// Decodes PS/2 make codes and debounced shake sensors into per-player arrow
// events, suppressing break codes and typematic repeats, queued in small FIFOs.
module multi_player_input_queue #(
    parameter int                      NUM_PLAYERS     = 2,
    parameter int                      FIFO_DEPTH      = 4,
    parameter int                      DEBOUNCE_CYCLES = 50000,
    parameter logic [32*NUM_PLAYERS-1:0] KEYMAP        = 64'h7472_6b75_231b_1c1d
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        clear,
    multi_player_input_queue_if.master  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [2:0]    CODE_SHAKE = 3'd5;

    logic                   r_break_flag;
    logic [3:0]             r_held      [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_sync1, r_sync2, r_deb, r_shake_pend, r_valid, r_overflow;
    logic [DW-1:0]          r_db_cnt    [NUM_PLAYERS];
    logic [2:0]             r_mem       [NUM_PLAYERS][FIFO_DEPTH];
    logic [PW-1:0]          r_wptr      [NUM_PLAYERS];
    logic [PW-1:0]          r_rptr      [NUM_PLAYERS];
    logic [CW-1:0]          r_count     [NUM_PLAYERS];
    logic [7:0]             r_arrow     [NUM_PLAYERS];

    logic                   w_strobe, w_is_e0, w_is_f0;
    logic [NUM_PLAYERS-1:0] w_kb_wr, w_flip, w_rise, w_wr, w_pop, w_push, w_drop, w_pend_nxt;
    logic [2:0]             w_kb_code   [NUM_PLAYERS];
    logic [2:0]             w_wdata     [NUM_PLAYERS];
    logic [3:0]             w_held_nxt  [NUM_PLAYERS];
    logic [PW-1:0]          w_rptr_nxt  [NUM_PLAYERS];
    logic [CW-1:0]          w_count_nxt [NUM_PLAYERS];
    logic [7:0]             w_arrow_nxt [NUM_PLAYERS];

    assign w_strobe = bus.ps2_key_pressed & ~clear;
    assign w_is_e0  = (bus.ps2_key_data == 8'hE0);
    assign w_is_f0  = (bus.ps2_key_data == 8'hF0);

    // Scan-code match: a make with the key not held fires once; a break releases it.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_kb_wr[p]    = 1'b0;
            w_kb_code[p]  = 3'd0;
            w_held_nxt[p] = r_held[p];
            for (int k = 0; k < 4; k++) begin
                if (w_strobe && !w_is_e0 && !w_is_f0 &&
                    (KEYMAP[32*p+8*k +: 8] == bus.ps2_key_data)) begin
                    if (r_break_flag) begin
                        w_held_nxt[p][k] = 1'b0;
                    end else if (!r_held[p][k] && !w_kb_wr[p]) begin
                        w_kb_wr[p]       = 1'b1;
                        w_kb_code[p]     = 3'(k + 1);
                        w_held_nxt[p][k] = 1'b1;
                    end else begin
                        w_held_nxt[p][k] = r_held[p][k];
                    end
                end else begin
                    w_held_nxt[p][k] = r_held[p][k];
                end
            end
        end
    end

    // Debounce edge detect, write-port arbitration and FIFO next state.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_flip[p]      = (r_sync2[p] != r_deb[p]) && (r_db_cnt[p] == DB_LAST);
            w_rise[p]      = w_flip[p] & ~r_deb[p];
            w_wr[p]        = w_kb_wr[p] | r_shake_pend[p];
            w_wdata[p]     = w_kb_wr[p] ? w_kb_code[p] : CODE_SHAKE;
            // A pending shake survives a keyboard collision; a new rise merges into it.
            w_pend_nxt[p]  = w_rise[p] | (r_shake_pend[p] & w_kb_wr[p]);
            w_pop[p]       = r_valid[p] & bus.out_ready[p];
            w_push[p]      = w_wr[p] & ((r_count[p] != CNT_FULL) | w_pop[p]);
            w_drop[p]      = w_wr[p] & ~w_push[p];
            w_rptr_nxt[p]  = r_rptr[p] + PW'(w_pop[p]);
            w_count_nxt[p] = r_count[p] + CW'(w_push[p]) - CW'(w_pop[p]);
            if (w_count_nxt[p] == {CW{1'b0}}) begin
                w_arrow_nxt[p] = 8'h00;
            end else if (w_push[p] && (r_wptr[p] == w_rptr_nxt[p])) begin
                w_arrow_nxt[p] = {5'b00000, w_wdata[p]};
            end else begin
                w_arrow_nxt[p] = {5'b00000, r_mem[p][w_rptr_nxt[p]]};
            end
        end
    end

    // Parser flag, key-held bits, shake synchroniser and debouncer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_break_flag <= 1'b0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_deb        <= '0;
            r_shake_pend <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_held[p]   <= 4'b0000;
                r_db_cnt[p] <= '0;
            end
        end else if (clear) begin
            r_break_flag <= 1'b0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_deb        <= '0;
            r_shake_pend <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_held[p]   <= 4'b0000;
                r_db_cnt[p] <= '0;
            end
        end else begin
            if (w_strobe && w_is_f0) begin
                r_break_flag <= 1'b1;
            end else if (w_strobe && !w_is_e0) begin
                r_break_flag <= 1'b0;
            end else begin
                r_break_flag <= r_break_flag;
            end
            r_sync1      <= bus.shake_in;
            r_sync2      <= r_sync1;
            r_shake_pend <= w_pend_nxt;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_held[p] <= w_held_nxt[p];
                if (r_sync2[p] == r_deb[p]) begin
                    r_db_cnt[p] <= '0;
                end else if (w_flip[p]) begin
                    r_db_cnt[p] <= '0;
                    r_deb[p]    <= ~r_deb[p];
                end else begin
                    r_db_cnt[p] <= r_db_cnt[p] + DW'(1);
                end
            end
        end
    end

    // Per-player FIFO storage, pointers and registered head/valid/overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid    <= '0;
            r_overflow <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_wptr[p]  <= '0;
                r_rptr[p]  <= '0;
                r_count[p] <= '0;
                r_arrow[p] <= 8'h00;
                for (int d = 0; d < FIFO_DEPTH; d++) r_mem[p][d] <= 3'd0;
            end
        end else if (clear) begin
            r_valid    <= '0;
            r_overflow <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_wptr[p]  <= '0;
                r_rptr[p]  <= '0;
                r_count[p] <= '0;
                r_arrow[p] <= 8'h00;
                for (int d = 0; d < FIFO_DEPTH; d++) r_mem[p][d] <= 3'd0;
            end
        end else begin
            r_overflow <= r_overflow | w_drop;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (w_push[p]) begin
                    r_mem[p][r_wptr[p]] <= w_wdata[p];
                    r_wptr[p]           <= r_wptr[p] + PW'(1);
                end else begin
                    r_wptr[p] <= r_wptr[p];
                end
                r_rptr[p]  <= w_rptr_nxt[p];
                r_count[p] <= w_count_nxt[p];
                r_arrow[p] <= w_arrow_nxt[p];
                r_valid[p] <= (w_count_nxt[p] != {CW{1'b0}});
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.overflow  = r_overflow;
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_arrow
        assign bus.out_arrow[8*g +: 8] = r_arrow[g];
    end
endmodule

// File: tb/tb_multi_player_input_queue.sv
// Bench for multi_player_input_queue: directed vector table, shake corner
// sequences and random traffic against a queue-level reference model.
module tb_multi_player_input_queue;
    localparam int          NP    = 2;
    localparam int          DEPTH = 4;
    localparam int          DEB   = 4;
    localparam logic [63:0] KM    = 64'h7472_6b75_231b_1c1d;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic clear  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic seen;
    int   extra;

    multi_player_input_queue_if #(.NUM_PLAYERS(NP)) bus ();

    multi_player_input_queue #(
        .NUM_PLAYERS(NP), .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .KEYMAP(KM)
    ) dut (
        .clock(clock), .resetn(resetn), .clear(clear), .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        strobe;
        logic [7:0]  data;
        logic        clr;
        logic [1:0]  ready;
        logic [1:0]  exp_valid;
        logic [15:0] exp_arrow;
        logic [1:0]  exp_ovf;
    } vec_t;
    vec_t vecs[$];

    // Reference model: shift-register FIFOs, held-key sets, delayed shake samples.
    logic [7:0]    m_fifo [NP][DEPTH];
    int            m_cnt  [NP];
    logic [3:0]    m_held [NP];
    logic [DEB-1:0] m_win [NP];
    logic          m_brk;
    logic [NP-1:0] m_ovf, m_pend, m_deb, m_d1, m_d2;

    function automatic vec_t mkv(logic s, logic [7:0] d, logic c, logic [1:0] r,
                                 logic [1:0] ev, logic [15:0] ea, logic [1:0] eo);
        vec_t v;
        v.strobe = s; v.data = d; v.clr = c; v.ready = r;
        v.exp_valid = ev; v.exp_arrow = ea; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_brk = 1'b0; m_ovf = '0; m_pend = '0; m_deb = '0; m_d1 = '0; m_d2 = '0;
        for (int p = 0; p < NP; p++) begin
            m_cnt[p] = 0; m_held[p] = 4'b0000; m_win[p] = '0;
            for (int d = 0; d < DEPTH; d++) m_fifo[p][d] = 8'h00;
        end
    endtask

    task automatic model_step();
        logic [NP-1:0] ev;
        logic [2:0]    code [NP];
        logic          flip, wr;
        logic [7:0]    wd;
        ev = '0;
        for (int p = 0; p < NP; p++) code[p] = 3'd0;
        if (clear) begin
            model_reset();
        end else begin
            if (bus.ps2_key_pressed && bus.ps2_key_data != 8'hE0) begin
                if (bus.ps2_key_data == 8'hF0) begin
                    m_brk = 1'b1;
                end else begin
                    for (int p = 0; p < NP; p++)
                        for (int k = 0; k < 4; k++)
                            if (KM[32*p+8*k +: 8] == bus.ps2_key_data) begin
                                if (m_brk) m_held[p][k] = 1'b0;
                                else if (!m_held[p][k] && !ev[p]) begin
                                    ev[p] = 1'b1; code[p] = 3'(k + 1); m_held[p][k] = 1'b1;
                                end
                            end
                    m_brk = 1'b0;
                end
            end
            for (int p = 0; p < NP; p++) begin
                m_win[p] = {m_win[p][DEB-2:0], m_d2[p]};
                flip = (m_win[p] == {DEB{~m_deb[p]}});
                if (flip) m_deb[p] = ~m_deb[p];
                wr = ev[p] | m_pend[p];
                wd = ev[p] ? {5'd0, code[p]} : 8'h05;
                m_pend[p] = (flip && m_deb[p]) || (m_pend[p] && ev[p]);
                if (m_cnt[p] > 0 && bus.out_ready[p]) begin
                    for (int d = 0; d < DEPTH - 1; d++) m_fifo[p][d] = m_fifo[p][d+1];
                    m_cnt[p]--;
                end
                if (wr) begin
                    if (m_cnt[p] < DEPTH) begin
                        m_fifo[p][m_cnt[p]] = wd; m_cnt[p]++;
                    end else m_ovf[p] = 1'b1;
                end
            end
            m_d2 = m_d1;
            m_d1 = bus.shake_in;
        end
    endtask

    task automatic tick();
        logic [NP-1:0]   ev;
        logic [8*NP-1:0] ea;
        @(posedge clock);
        if (!resetn) model_reset(); else model_step();
        #1;
        for (int p = 0; p < NP; p++) begin
            ev[p]        = (m_cnt[p] != 0);
            ea[8*p +: 8] = (m_cnt[p] != 0) ? m_fifo[p][0] : 8'h00;
        end
        chk("model_valid", 32'(bus.out_valid), 32'(ev));
        chk("model_arrow", 32'(bus.out_arrow), 32'(ea));
        chk("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [7:0] r;
        int idx;
        bus.ps2_key_pressed = 1'b0; bus.ps2_key_data = 8'h00;
        bus.shake_in = '0; bus.out_ready = '0;
        model_reset();
        #12;
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_arrow", 32'(bus.out_arrow), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        resetn = 1'b1;
        tick();

        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'hE0, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h75, 0, 2'b00, 2'b11, 16'h0101, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b11, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b01, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b01, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 1, 2'b00, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1b, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1b, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h23, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h23, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b01));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0001, 2'b01));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b01));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b01, 2'b01, 16'h0002, 2'b01));
        vecs.push_back(mkv(0, 8'h00, 1, 2'b00, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 1, 2'b00, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'h1d, 0, 2'b00, 2'b01, 16'h0001, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b01, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 1, 2'b00, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b00, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'hF0, 1, 2'b00, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(1, 8'h1c, 0, 2'b00, 2'b01, 16'h0002, 2'b00));
        vecs.push_back(mkv(1, 8'h72, 0, 2'b00, 2'b11, 16'h0302, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b11, 2'b00, 16'h0000, 2'b00));
        vecs.push_back(mkv(0, 8'h00, 0, 2'b11, 2'b00, 16'h0000, 2'b00));

        foreach (vecs[i]) begin
            bus.ps2_key_pressed = vecs[i].strobe; bus.ps2_key_data = vecs[i].data;
            clear = vecs[i].clr; bus.out_ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_arrow", i), 32'(bus.out_arrow), 32'(vecs[i].exp_arrow));
            chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
        end
        bus.ps2_key_pressed = 1'b0; clear = 1'b0; bus.out_ready = '0;

        // Shake on player 1 with a short glitch, then a clean second press.
        clear = 1'b1; tick(); clear = 1'b0;
        bus.shake_in = 2'b10; repeat (2) tick();
        bus.shake_in = 2'b00; repeat (3) tick();
        bus.shake_in = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.out_valid[1]) seen = 1'b1; end
        chk("shake_early", 32'(seen), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = bus.out_valid[1]; end
        chk("shake_seen", 32'(seen), 32'd1);
        chk("shake_code", 32'(bus.out_arrow[15:8]), 32'h05);
        bus.out_ready = 2'b10; tick(); bus.out_ready = 2'b00;
        extra = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.out_valid[1]) extra++; end
        chk("shake_single", 32'(extra), 32'd0);
        bus.shake_in = 2'b00; repeat (5) tick();
        bus.shake_in = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin tick(); seen = bus.out_valid[1]; end
        chk("shake_second", 32'(seen), 32'd1);
        chk("shake_second_code", 32'(bus.out_arrow[15:8]), 32'h05);
        bus.out_ready = 2'b10; tick(); bus.out_ready = 2'b00;

        // Shake write collides with a player 1 keyboard make.
        bus.shake_in = 2'b00; clear = 1'b1; tick(); clear = 1'b0;
        bus.shake_in = 2'b10; repeat (6) tick();
        bus.ps2_key_pressed = 1'b1; bus.ps2_key_data = 8'h74; tick();
        bus.ps2_key_pressed = 1'b0;
        chk("collide_first", 32'(bus.out_arrow[15:8]), 32'h04);
        tick();
        chk("collide_overflow", 32'(bus.overflow), 32'd0);
        bus.out_ready = 2'b10; tick();
        chk("collide_second", 32'(bus.out_arrow[15:8]), 32'h05);
        tick();
        chk("collide_empty", 32'(bus.out_valid[1]), 32'd0);
        bus.out_ready = 2'b00;

        // Random traffic checked every cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            idx = $urandom_range(0, 11);
            if (idx < 8) r = KM[8*idx +: 8];
            else if (idx == 8) r = 8'hE0;
            else if (idx < 11) r = 8'hF0;
            else r = 8'($urandom);
            bus.ps2_key_pressed = ($urandom_range(0, 99) < 50);
            bus.ps2_key_data    = r;
            for (int p = 0; p < NP; p++) begin
                bus.out_ready[p] = ($urandom_range(0, 99) < 30);
                if ($urandom_range(0, 15) == 0) bus.shake_in[p] = ~bus.shake_in[p];
            end
            clear = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
